// File: rtl/seg_display_sched.sv
// seg_display_sched
// 4-digit 7-segment scan scheduler. A clock prescaler produces digit-scan
// ticks, a sequential double-dabble turns the binary score into BCD, and a
// tick-synchronous arbiter chooses between the score and a blinking "dEAd".
// Optional feature macro: SEG_LZB_EN (leading-zero blanking in score mode).
module seg_display_sched #(
  parameter int SCAN_DIV  = 32768,
  parameter int BLINK_DIV = 256
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [13:0] score,
  input  logic        score_vld,
  input  logic        p_dead,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [3:0] ITERS     = 4'd14;
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  // The display only has four digits, so anything larger saturates.
  function automatic logic [13:0] sat_score(input logic [13:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

  // ---------------------------------------------------------------------
  // Scan prescaler
  // ---------------------------------------------------------------------
  logic [SW-1:0] scan_cnt;
  logic          scan_tick;

  assign scan_tick = (scan_cnt == SW'(SCAN_DIV - 1));

  // Free-running divider; wraps on the terminal count that raises the tick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)            scan_cnt <= '0;
    else if (scan_tick) scan_cnt <= '0;
    else                scan_cnt <= scan_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Binary -> BCD conversion
  // ---------------------------------------------------------------------
  typedef enum logic {S_IDLE, S_CONV} conv_st_t;

  conv_st_t    conv_st;
  logic [13:0] bin_sr;
  logic [15:0] bcd_sr;
  logic [15:0] bcd_adj;
  logic [3:0]  iter;
  logic        pend;
  logic [13:0] pend_val;
  logic [15:0] disp_bcd;

  assign bcd_adj = dabble_adj(bcd_sr);

  // Conversion FSM: 14 shift iterations, then an atomic commit to disp_bcd.
  // A score arriving mid-conversion is parked in pend_val (newest wins) and
  // picked up at the commit edge so busy never drops between conversions.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      conv_st  <= S_IDLE;
      busy     <= 1'b0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      iter     <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      disp_bcd <= '0;
    end else begin
      case (conv_st)
        S_IDLE: begin
          if (score_vld) begin
            bin_sr  <= sat_score(score);
            bcd_sr  <= '0;
            iter    <= '0;
            busy    <= 1'b1;
            conv_st <= S_CONV;
          end
        end
        S_CONV: begin
          if (iter != ITERS) begin
            bcd_sr <= {bcd_adj[14:0], bin_sr[13]};
            bin_sr <= {bin_sr[12:0], 1'b0};
            iter   <= iter + 1'b1;
            if (score_vld) begin
              pend     <= 1'b1;
              pend_val <= sat_score(score);
            end
          end else begin
            // Commit edge: publish the result, then restart or go idle.
            disp_bcd <= bcd_sr;
            bcd_sr   <= '0;
            iter     <= '0;
            if (score_vld) begin
              bin_sr <= sat_score(score);
              pend   <= 1'b0;
            end else if (pend) begin
              bin_sr <= pend_val;
              pend   <= 1'b0;
            end else begin
              busy    <= 1'b0;
              conv_st <= S_IDLE;
            end
          end
        end
        default: begin
          conv_st <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Digit selection
  // ---------------------------------------------------------------------
  logic [1:0] dig_idx;
  logic [3:0] cur_nib;
  logic [3:0] an_pat;
  logic [6:0] dead_seg;
  logic [6:0] score_seg;

  // Per-index nibble, anode pattern and "dEAd" letter; index 0 is leftmost.
  always_comb begin
    cur_nib  = disp_bcd[15:12];
    an_pat   = 4'b0111;
    dead_seg = SEG_D;
    case (dig_idx)
      2'd0: begin cur_nib = disp_bcd[15:12]; an_pat = 4'b0111; dead_seg = SEG_D; end
      2'd1: begin cur_nib = disp_bcd[11:8];  an_pat = 4'b1011; dead_seg = SEG_E; end
      2'd2: begin cur_nib = disp_bcd[7:4];   an_pat = 4'b1101; dead_seg = SEG_A; end
      default: begin cur_nib = disp_bcd[3:0]; an_pat = 4'b1110; dead_seg = SEG_D; end
    endcase
  end

`ifdef SEG_LZB_EN
  logic lead_zero;

  // A digit is a leading zero when it and every digit to its left are 0;
  // the units digit is never blanked so a zero score still shows "0".
  always_comb begin
    lead_zero = 1'b0;
    case (dig_idx)
      2'd0:    lead_zero = (disp_bcd[15:12] == 4'd0);
      2'd1:    lead_zero = (disp_bcd[15:8]  == 8'd0);
      2'd2:    lead_zero = (disp_bcd[15:4]  == 12'd0);
      default: lead_zero = 1'b0;
    endcase
  end

  assign score_seg = lead_zero ? SEG_BLANK : bcd_to_seg(cur_nib);
`else
  assign score_seg = bcd_to_seg(cur_nib);
`endif

  // ---------------------------------------------------------------------
  // Mode arbitration and blink
  // ---------------------------------------------------------------------
  logic          dead_mode;
  logic          dead_rise;
  logic [BW-1:0] blink_cnt;
  logic          blink_wrap;
  logic          blink_on;
  logic          blink_on_nx;

  assign dead_rise  = p_dead & ~dead_mode;
  assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));

  // Phase that applies to the digit being registered on this tick: entering
  // dead mode always starts visible, otherwise toggle on counter wrap.
  always_comb begin
    blink_on_nx = blink_on;
    if (dead_rise)                blink_on_nx = 1'b1;
    else if (p_dead && blink_wrap) blink_on_nx = ~blink_on;
  end

  // Mode and blink state move only on scan ticks so a frame is never torn.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dead_mode <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (scan_tick) begin
      dead_mode <= p_dead;
      blink_on  <= blink_on_nx;
      if (dead_rise)   blink_cnt <= '0;
      else if (p_dead) blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Scan output registers
  // ---------------------------------------------------------------------
  // Register the current digit and step the index on every tick; p_dead is
  // used directly so a mode change takes effect on the same tick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dig_idx <= 2'd0;
      seg     <= SEG_BLANK;
      an      <= 4'b1111;
    end else if (scan_tick) begin
      dig_idx <= dig_idx + 2'd1;
      if (p_dead) begin
        seg <= blink_on_nx ? dead_seg : SEG_BLANK;
        an  <= blink_on_nx ? an_pat   : 4'b1111;
      end else begin
        seg <= score_seg;
        an  <= an_pat;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Bench for seg_display_sched (SCAN_DIV=4, BLINK_DIV=2). A tick/frame level
// reference model runs alongside the DUT; table vectors and hand sequences
// cover the spec corner cases, then randomized traffic. Honors SEG_LZB_EN.
module tb_seg_display_sched;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  localparam logic [6:0] SEGTAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] DEADTAB [4] = '{
    7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001};

  logic        clk = 1'b0;
  logic        clr;
  logic [13:0] score;
  logic        score_vld;
  logic        p_dead;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int checks;
  int failures;

  seg_display_sched #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .clr(clr), .score(score), .score_vld(score_vld),
    .p_dead(p_dead), .seg(seg), .an(an), .busy(busy));

  always #5 clk = ~clk;

  // ---------------- reference model (state after each edge) ----------------
  int   ncyc, ntick, dead_ticks, disp_val, cur_v, pend_v, end_cyc;
  bit   active, pend_valid, prev_dead, m_tick;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  logic [6:0] frame [4];

  function automatic int clamp(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [6:0] score_seg_ref(int v, int k);
    int d;
    d = (k == 0) ? v / 1000 : (k == 1) ? (v / 100) % 10 :
        (k == 2) ? (v / 10) % 10 : v % 10;
`ifdef SEG_LZB_EN
    if ((k == 0 && v < 1000) || (k == 1 && v < 100) || (k == 2 && v < 10))
      return 7'h7f;
`endif
    return SEGTAB[d];
  endfunction

  function automatic logic [3:0] an_of(int k);
    logic [3:0] oh;
    oh = 4'b1000;
    oh = oh >> k;
    return ~oh;
  endfunction

  task automatic model_reset();
    ncyc = 0; ntick = 0; dead_ticks = 0; disp_val = 0; cur_v = 0;
    pend_v = 0; end_cyc = 0; active = 0; pend_valid = 0; prev_dead = 0;
    m_tick = 0; m_seg = 7'h7f; m_an = 4'hf;
  endtask

  task automatic model_edge();
    int k;
    bit on;
    ncyc++;
    m_tick = (ncyc % SCAN_DIV) == 0;
    if (m_tick) begin
      k = ntick % 4;
      ntick++;
      if (p_dead) begin
        if (!prev_dead) dead_ticks = 0; else dead_ticks++;
        on    = ((dead_ticks / BLINK_DIV) % 2) == 0;
        m_an  = on ? an_of(k) : 4'hf;
        m_seg = on ? DEADTAB[k] : 7'h7f;
      end else begin
        m_an  = an_of(k);
        m_seg = score_seg_ref(disp_val, k);
      end
      prev_dead = p_dead;
    end
    // conversion: start edge + 15 = commit edge
    if (active && ncyc == end_cyc) begin
      disp_val = cur_v;
      if (score_vld) begin
        cur_v = clamp(int'(score)); end_cyc = ncyc + 15; pend_valid = 0;
      end else if (pend_valid) begin
        cur_v = pend_v; end_cyc = ncyc + 15; pend_valid = 0;
      end else active = 0;
    end else if (active) begin
      if (score_vld) begin pend_valid = 1; pend_v = clamp(int'(score)); end
    end else if (score_vld) begin
      active = 1; cur_v = clamp(int'(score)); end_cyc = ncyc + 15;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg", seg, m_seg);
    check("an", an, m_an);
    check("busy", busy, active);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    check("rst_seg", seg, 7'h7f);
    check("rst_an", an, 4'hf);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
  endtask

  task automatic pulse(int v);
    score = 14'(v);
    score_vld = 1'b1;
    step();
    score_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy === 1'b1 && c < 100) begin step(); c++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic capture_frame();
    for (int k = 0; k < 4; k++) frame[k] = 'x;
    for (int c = 0; c < 8 * SCAN_DIV; c++) begin
      step();
      for (int k = 0; k < 4; k++) if (an === an_of(k)) frame[k] = seg;
    end
  endtask

  typedef struct packed {
    logic [13:0] sc;
    logic [6:0]  s0, s1, s2, s3;
  } vec_t;

  // ---------------- test ----------------
  initial begin
    vec_t       tbl [8];
    logic [3:0] ans [5];
    logic [6:0] exp42 [4];
    int nt, cnt;

    clr = 1'b0; score = '0; score_vld = 1'b0; p_dead = 1'b0;
    checks = 0; failures = 0;
    model_reset();

    tbl[0] = '{14'd1234,  7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    tbl[1] = '{14'd12000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000};
    tbl[2] = '{14'd16383, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000};
    tbl[3] = '{14'd9999,  7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000};
    tbl[4] = '{14'd5060,  7'b0010010, 7'b1000000, 7'b0000010, 7'b1000000};
`ifdef SEG_LZB_EN
    tbl[5] = '{14'd7,  7'h7f, 7'h7f, 7'h7f, 7'b1111000};
    tbl[6] = '{14'd0,  7'h7f, 7'h7f, 7'h7f, 7'b1000000};
    tbl[7] = '{14'd80, 7'h7f, 7'h7f, 7'b0000000, 7'b1000000};
    exp42  = '{7'h7f, 7'h7f, 7'b0011001, 7'b0100100};
`else
    tbl[5] = '{14'd7,  7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000};
    tbl[6] = '{14'd0,  7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    tbl[7] = '{14'd80, 7'b1000000, 7'b1000000, 7'b0000000, 7'b1000000};
    exp42  = '{7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100};
`endif

    #2;
    do_reset();

    // first tick after release lights the leftmost digit
    cnt = 0;
    while (an === 4'hf && cnt < 4 * SCAN_DIV) begin step(); cnt++; end
    check("first_tick_an", an, 4'b0111);
    check("first_tick_cyc", cnt, SCAN_DIV);

    // busy: high on the 14 clocks after capture, low on the 15th
    pulse(1234);
    check("busy_cap", busy, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      step();
      check($sformatf("busy_hi%0d", i), busy, 1'b1);
    end
    step();
    check("busy_lo15", busy, 1'b0);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      pulse(int'(tbl[i].sc));
      wait_idle();
      capture_frame();
      check($sformatf("vec%0d_d0", i), frame[0], tbl[i].s0);
      check($sformatf("vec%0d_d1", i), frame[1], tbl[i].s1);
      check($sformatf("vec%0d_d2", i), frame[2], tbl[i].s2);
      check($sformatf("vec%0d_d3", i), frame[3], tbl[i].s3);
    end

    // 12000 then 5 and 42 during conversion: newest pending wins, busy continuous
    pulse(12000);
    repeat (3) step();
    pulse(5);
    repeat (2) step();
    pulse(42);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin step(); cnt++; end
    check("busy_cont", cnt, 23);
    capture_frame();
    for (int k = 0; k < 4; k++) check($sformatf("pend42_d%0d", k), frame[k], exp42[k]);

    // score_vld on the commit edge restarts immediately
    pulse(100);
    repeat (14) step();
    pulse(200);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin step(); cnt++; end
    check("done_coinc", cnt, 15);

    // dead mode: 2 ticks on, 2 off, then on again
    p_dead = 1'b1;
    nt = 0;
    for (int c = 0; c < 10 * SCAN_DIV && nt < 5; c++) begin
      step();
      if (m_tick) begin ans[nt] = an; nt++; end
    end
    check("dead_ntick", nt, 5);
    check("dead_on0", ans[0] !== 4'hf, 1'b1);
    check("dead_on1", ans[1] !== 4'hf, 1'b1);
    check("dead_off2", ans[2], 4'hf);
    check("dead_off3", ans[3], 4'hf);
    check("dead_on4", ans[4] !== 4'hf, 1'b1);
    p_dead = 1'b0;
    nt = 0;
    for (int c = 0; c < 2 * SCAN_DIV && nt < 1; c++) begin
      step();
      if (m_tick) nt++;
    end
    check("alive_an_lit", an !== 4'hf, 1'b1);

    // reset in the middle of a conversion
    pulse(4321);
    repeat (5) step();
    do_reset();
    capture_frame();
    check("rstmid_d0", frame[0], tbl[6].s0);
    check("rstmid_d1", frame[1], tbl[6].s1);
    check("rstmid_d2", frame[2], tbl[6].s2);
    check("rstmid_d3", frame[3], tbl[6].s3);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      score     = 14'($urandom_range(0, 16383));
      score_vld = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 59) == 0) p_dead = ~p_dead;
      step();
    end
    score_vld = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
